uart_echo_fifo: RTL and testbench
=================================

UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter DATA_W, default 8, character width in bits.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 Parameter CNT_W, default clog2(DEPTH+1), width of fifo_count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_data  input  DATA_W  received character from UART_rx data_out.
REQ-007 rx_new  input  1  UART_rx new_data flag; held high until acknowledged.
REQ-008 rx_read  output  1  one-cycle acknowledge pulse to UART_rx read.
REQ-009 tx_busy  input  1  UART_tx busy.
REQ-010 tx_load  output  1  one-cycle load pulse to UART_tx.
REQ-011 tx_data  output  DATA_W  character to UART_tx, registered, valid while tx_load=1.
REQ-012 mode  input  2  00 echo, 01 upper-case echo, 10 hold, 11 flush.
REQ-013 ovf_clr  input  1  clears overflow.
REQ-014 fifo_count  output  CNT_W  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky flag: character dropped because FIFO full.
REQ-016 rx_total  output  16  count of accepted characters, wraps 0xFFFF->0x0000.

Function
REQ-017 RX FSM states RX_IDLE, RX_ACK; RX_IDLE with rx_new=1 -> rx_read=1 next cycle, enter RX_ACK.
REQ-018 RX_ACK returns to RX_IDLE on first cycle rx_new=0; no further rx_read while in RX_ACK.
REQ-019 Character written to FIFO in the rx_read cycle when not full and mode!=11; rx_total increments same cycle.
REQ-020 FIFO full at rx_read: character dropped, rx_read still pulsed, overflow set next cycle, rx_total unchanged.
REQ-021 mode=01, DATA_W=8: bytes 0x61..0x7A stored minus 0x20; all other values and widths stored unchanged.
REQ-022 mode=10: characters accepted and stored; no transmission started.
REQ-023 mode=11: FIFO emptied in one cycle (count 0 next cycle); incoming characters acked and discarded, not counted.
REQ-024 TX FSM states TX_IDLE, TX_START, TX_BUSY.
REQ-025 TX_IDLE, FIFO not empty, tx_busy=0, mode in {00,01} -> tx_load=1 one cycle with FIFO head on tx_data, pop same cycle, enter TX_START.
REQ-026 TX_START -> TX_BUSY when tx_busy=1; TX_START with tx_busy=0 for 2 consecutive cycles -> TX_IDLE.
REQ-027 TX_BUSY -> TX_IDLE when tx_busy=0.
REQ-028 Simultaneous push and pop: fifo_count unchanged, both take effect; pop of empty never occurs.
REQ-029 Mode change to 10/11 mid-transmission: current character completes; no new tx_load afterwards.
REQ-030 Pointers wrap modulo DEPTH; full when count=DEPTH, empty when count=0.
REQ-031 ovf_clr=1 clears overflow; simultaneous new drop and ovf_clr leaves overflow=1.
REQ-032 Minimum latency rx_new rising to tx_load: 3 cycles (ack, write, load) with empty FIFO, idle TX.

Reset
REQ-033 rst_n=0 sampled on clk: both FSMs to idle, pointers and count 0, rx_read=0, tx_load=0, tx_data=0, overflow=0, rx_total=0.
REQ-034 Reset mid-operation discards FIFO contents and abandons any handshake; no pulses during or in the first cycle after reset.
REQ-035 FIFO storage array not reset.

Structure
REQ-036 Package uart_echo_pkg holds mode encodings (MODE_ECHO, MODE_UPPER, MODE_HOLD, MODE_FLUSH) and RX/TX state encodings.
REQ-037 Storage, pointers, count and flush in sub-module sync_fifo (params DATA_W, DEPTH); FSMs, case transform, counters in top.

Verification
REQ-038 mode=00, send 0x41 with tx_busy model asserting 1 cycle after load for 10 cycles -> one tx_load, tx_data=0x41, rx_total=1, count back to 0.
REQ-039 mode=01, send 0x61,0x7A,0x7B,0x5A -> transmitted 0x41,0x5A,0x7B,0x5A in order.
REQ-040 mode=10, send 17 bytes 0x00..0x10 -> fifo_count=16, overflow=1, rx_total=16, 17 rx_read pulses, no tx_load; then mode=00 -> 0x00..0x0F transmitted.
REQ-041 mode=10 with 5 queued, mode=11 one cycle -> fifo_count=0 next cycle; byte 0x33 sent in flush -> rx_read pulse, count 0, rx_total unchanged.
REQ-042 tx_busy held 0 after tx_load -> TX returns to idle after 2 cycles, next byte loaded.
REQ-043 rst_n=0 mid-transfer with count=3 -> all outputs zero next cycle, no tx_load until new data arrives.

Source files
------------

// File: rtl/uart_echo_fifo_pkg.sv
// Shared encodings for the UART echo path: operating modes, FSM states and
// the ASCII constants used by the upper-case transform.
package uart_echo_pkg;

   typedef enum logic [1:0] {
      MODE_ECHO  = 2'b00,
      MODE_UPPER = 2'b01,
      MODE_HOLD  = 2'b10,
      MODE_FLUSH = 2'b11
   } mode_e;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_ACK  = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'b00,
      TX_START = 2'b01,
      TX_BUSY  = 2'b10
   } tx_state_e;

   localparam logic [7:0] ASCII_LOWER_A = 8'h61;
   localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
   localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count and a one-cycle flush.
// Head data is presented combinationally; storage is deliberately not reset.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [DATA_W-1:0]            wr_data_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [DATA_W-1:0]            rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o && !flush_i;
   assign do_pop    = pop_i && !empty_o && !flush_i;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echoes characters from a UART receiver to a UART transmitter through a FIFO,
// with upper-case, hold and flush modes plus overflow and traffic counters.
module uart_echo_fifo
   import uart_echo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_new,
   output logic              rx_read,
   input  logic              tx_busy,
   output logic              tx_load,
   output logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        mode,
   input  logic              ovf_clr,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow,
   output logic [15:0]       rx_total
);
   localparam int FCW = $clog2(DEPTH + 1);

   mode_e             mode_s;
   rx_state_e         rx_state_q;
   tx_state_e         tx_state_q;
   logic              rx_read_q, tx_load_q, start_idle_q, overflow_q;
   logic [DATA_W-1:0] tx_data_q, wr_data, head;
   logic [15:0]       rx_total_q;
   logic [FCW-1:0]    fcount;
   logic              full, empty, push, drop, pop, flush;

   function automatic logic [DATA_W-1:0] to_upper(input logic [DATA_W-1:0] c);
      logic [7:0] b;
      b = 8'(c);
      if (DATA_W == 8 && b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
         return DATA_W'(b - ASCII_CASE_OFS);
      return c;
   endfunction

   assign mode_s  = mode_e'(mode);
   assign flush   = (mode_s == MODE_FLUSH);
   // The acknowledge cycle is the write cycle; flush acks but discards.
   assign push    = rx_read_q && !full && !flush;
   assign drop    = rx_read_q && full && !flush;
   assign pop     = (tx_state_q == TX_IDLE) && !empty && !tx_busy &&
                    (mode_s == MODE_ECHO || mode_s == MODE_UPPER);
   assign wr_data = (mode_s == MODE_UPPER) ? to_upper(rx_data) : rx_data;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .wr_data_i (wr_data),
      .pop_i     (pop),
      .flush_i   (flush),
      .rd_data_o (head),
      .count_o   (fcount),
      .full_o    (full),
      .empty_o   (empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_read_q  <= 1'b0;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               rx_read_q <= rx_new;
               if (rx_new) rx_state_q <= RX_ACK;
            end
            RX_ACK: begin
               rx_read_q <= 1'b0;
               if (!rx_new) rx_state_q <= RX_IDLE;
            end
            default: begin
               rx_read_q  <= 1'b0;
               rx_state_q <= RX_IDLE;
            end
         endcase
      end
   end

   // TX_START gives the transmitter two cycles to raise busy before giving up.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q   <= TX_IDLE;
         tx_load_q    <= 1'b0;
         tx_data_q    <= '0;
         start_idle_q <= 1'b0;
      end else begin
         tx_load_q <= 1'b0;
         case (tx_state_q)
            TX_IDLE: begin
               if (pop) begin
                  tx_load_q    <= 1'b1;
                  tx_data_q    <= head;
                  start_idle_q <= 1'b0;
                  tx_state_q   <= TX_START;
               end
            end
            TX_START: begin
               if (tx_busy)           tx_state_q   <= TX_BUSY;
               else if (start_idle_q) tx_state_q   <= TX_IDLE;
               else                   start_idle_q <= 1'b1;
            end
            TX_BUSY: begin
               if (!tx_busy) tx_state_q <= TX_IDLE;
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         rx_total_q <= '0;
      end else begin
         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
         if (push) rx_total_q <= rx_total_q + 16'd1;
      end
   end

   assign rx_read    = rx_read_q;
   assign tx_load    = tx_load_q;
   assign tx_data    = tx_data_q;
   assign overflow   = overflow_q;
   assign rx_total   = rx_total_q;
   assign fifo_count = CNT_W'(fcount);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo with a UART rx/tx handshake model.
module tb_uart_echo_fifo;
   import uart_echo_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_new;
   logic        rx_read;
   logic        tx_busy;
   logic        tx_load;
   logic [7:0]  tx_data;
   logic [1:0]  mode;
   logic        ovf_clr;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic [15:0] rx_total;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_load   = 0;
   int n_read   = 0;
   int busy_len = 0;
   int pend     = 0;
   logic [7:0] txq[$];
   int         ldcyc[$];

   uart_echo_fifo #(.DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_new     (rx_new),
      .rx_read    (rx_read),
      .tx_busy    (tx_busy),
      .tx_load    (tx_load),
      .tx_data    (tx_data),
      .mode       (mode),
      .ovf_clr    (ovf_clr),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .rx_total   (rx_total)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transmitter model: busy rises the cycle after a load and lasts busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (pend > 0) begin
            tx_busy = 1'b1;
            pend--;
         end else begin
            tx_busy = 1'b0;
         end
         if (rx_read === 1'b1) n_read++;
         if (tx_load === 1'b1) begin
            n_load++;
            txq.push_back(tx_data);
            ldcyc.push_back(cyc);
            pend = busy_len;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_loads(input int target, input int budget);
      int k;
      k = 0;
      while (n_load < target && k < budget) begin
         tick();
         k++;
      end
   endtask

   // Receiver model: hold rx_new until acknowledged, then drop it for one cycle.
   task automatic send(input logic [7:0] b);
      int k;
      rx_data = b;
      rx_new  = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (rx_read !== 1'b1 && k < 10);
      n_checks++;
      if (rx_read !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ack: rx_read %b, required 1 for byte %h", rx_read, b);
      end
      tick();
      rx_new = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks += 6;
      if (rx_read !== 1'b0) begin n_fail++; $display("FAIL reset_rx_read: %b, required 0", rx_read); end
      if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: %b, required 0", tx_load); end
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: %h, required 00", tx_data); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: %0d, required 0", fifo_count); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: %b, required 0", overflow); end
      if (rx_total !== 16'd0) begin n_fail++; $display("FAIL reset_rx_total: %0d, required 0", rx_total); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_echo();
      int base, rbase, c;
      do_reset();
      mode = MODE_ECHO;
      busy_len = 10;
      base = n_load;
      rbase = n_read;
      c = cyc;
      send(8'h41);
      wait_loads(base + 1, 20);
      n_checks++;
      if (n_load <= base || ldcyc[base] - c != 3) begin
         n_fail++;
         $display("FAIL echo_latency: loads %0d, latency %0d, required 3",
                  n_load - base, (n_load > base) ? ldcyc[base] - c : -1);
      end
      repeat (20) tick();
      n_checks += 5;
      if (n_load - base != 1) begin n_fail++; $display("FAIL echo_loads: %0d, required 1", n_load - base); end
      if (n_load > base && txq[base] !== 8'h41) begin n_fail++; $display("FAIL echo_data: %h, required 41", txq[base]); end
      if (rx_total !== 16'd1) begin n_fail++; $display("FAIL echo_rx_total: %0d, required 1", rx_total); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL echo_count: %0d, required 0", fifo_count); end
      if (n_read - rbase != 1) begin n_fail++; $display("FAIL echo_reads: %0d, required 1", n_read - rbase); end
   endtask

   task automatic test_upper();
      logic [7:0] sent [4] = '{8'h61, 8'h7A, 8'h7B, 8'h5A};
      logic [7:0] want [4] = '{8'h41, 8'h5A, 8'h7B, 8'h5A};
      int base;
      do_reset();
      mode = MODE_UPPER;
      busy_len = 4;
      base = n_load;
      for (int i = 0; i < 4; i++) send(sent[i]);
      wait_loads(base + 4, 60);
      n_checks++;
      if (n_load - base != 4) begin n_fail++; $display("FAIL upper_loads: %0d, required 4", n_load - base); end
      for (int i = 0; i < 4; i++) begin
         if (n_load - base > i) begin
            n_checks++;
            if (txq[base + i] !== want[i]) begin
               n_fail++;
               $display("FAIL upper_data[%0d]: %h, required %h", i, txq[base + i], want[i]);
            end
         end
      end
   endtask

   task automatic test_hold_overflow();
      int base, rbase;
      do_reset();
      mode = MODE_HOLD;
      busy_len = 2;
      base = n_load;
      rbase = n_read;
      for (int i = 0; i < 17; i++) send(8'(i));
      n_checks += 5;
      if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL hold_count: %0d, required 16", fifo_count); end
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL hold_overflow: %b, required 1", overflow); end
      if (rx_total !== 16'd16) begin n_fail++; $display("FAIL hold_rx_total: %0d, required 16", rx_total); end
      if (n_read - rbase != 17) begin n_fail++; $display("FAIL hold_reads: %0d, required 17", n_read - rbase); end
      if (n_load != base) begin n_fail++; $display("FAIL hold_loads: %0d, required 0", n_load - base); end
      // Clear and a fresh drop land on the same edge: the drop must win.
      ovf_clr = 1'b1;
      rx_data = 8'h99;
      rx_new  = 1'b1;
      tick();
      n_checks++;
      if (rx_read !== 1'b1) begin n_fail++; $display("FAIL ovf_ack: rx_read %b, required 1", rx_read); end
      tick();
      rx_new = 1'b0;
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop: %b, required 1", overflow); end
      tick();
      n_checks += 2;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: %b, required 0", overflow); end
      if (rx_total !== 16'd16) begin n_fail++; $display("FAIL ovf_rx_total: %0d, required 16", rx_total); end
      ovf_clr = 1'b0;
      tick();
      mode = MODE_ECHO;
      wait_loads(base + 16, 200);
      repeat (5) tick();
      n_checks += 2;
      if (n_load - base != 16) begin n_fail++; $display("FAIL drain_loads: %0d, required 16", n_load - base); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL drain_count: %0d, required 0", fifo_count); end
      for (int i = 0; i < 16; i++) begin
         if (n_load - base > i) begin
            n_checks++;
            if (txq[base + i] !== 8'(i)) begin
               n_fail++;
               $display("FAIL drain_data[%0d]: %h, required %h", i, txq[base + i], 8'(i));
            end
         end
      end
   endtask

   task automatic test_flush();
      int base, rbase;
      do_reset();
      mode = MODE_HOLD;
      base = n_load;
      for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
      n_checks++;
      if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL flush_pre_count: %0d, required 5", fifo_count); end
      mode = MODE_FLUSH;
      tick();
      mode = MODE_HOLD;
      n_checks++;
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL flush_count: %0d, required 0", fifo_count); end
      mode = MODE_FLUSH;
      rbase = n_read;
      send(8'h33);
      n_checks += 3;
      if (n_read - rbase != 1) begin n_fail++; $display("FAIL flush_reads: %0d, required 1", n_read - rbase); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL flush_discard_count: %0d, required 0", fifo_count); end
      if (rx_total !== 16'd5) begin n_fail++; $display("FAIL flush_rx_total: %0d, required 5", rx_total); end
      mode = MODE_ECHO;
      repeat (10) tick();
      n_checks++;
      if (n_load != base) begin n_fail++; $display("FAIL flush_loads: %0d, required 0", n_load - base); end
   endtask

   task automatic test_back_to_back();
      int base, c;
      do_reset();
      mode = MODE_HOLD;
      busy_len = 0;
      base = n_load;
      send(8'hA5);
      send(8'h5A);
      mode = MODE_ECHO;
      c = cyc;
      wait_loads(base + 2, 30);
      n_checks++;
      if (n_load - base != 2) begin
         n_fail++;
         $display("FAIL b2b_loads: %0d, required 2", n_load - base);
      end else begin
         n_checks += 4;
         if (ldcyc[base] - c != 1) begin n_fail++; $display("FAIL b2b_first: %0d, required 1", ldcyc[base] - c); end
         if (ldcyc[base + 1] - ldcyc[base] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d, required 3", ldcyc[base + 1] - ldcyc[base]);
         end
         if (txq[base] !== 8'hA5) begin n_fail++; $display("FAIL b2b_data0: %h, required a5", txq[base]); end
         if (txq[base + 1] !== 8'h5A) begin n_fail++; $display("FAIL b2b_data1: %h, required 5a", txq[base + 1]); end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset();
      mode = MODE_ECHO;
      busy_len = 20;
      base = n_load;
      for (int i = 0; i < 4; i++) send(8'(8'h11 + i));
      n_checks += 2;
      if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL mid_count: %0d, required 3", fifo_count); end
      if (n_load - base != 1) begin n_fail++; $display("FAIL mid_loads: %0d, required 1", n_load - base); end
      rst_n = 1'b0;
      tick();
      n_checks += 6;
      if (rx_read !== 1'b0) begin n_fail++; $display("FAIL mid_rx_read: %b, required 0", rx_read); end
      if (tx_load !== 1'b0) begin n_fail++; $display("FAIL mid_tx_load: %b, required 0", tx_load); end
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: %h, required 00", tx_data); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL mid_rst_count: %0d, required 0", fifo_count); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: %b, required 0", overflow); end
      if (rx_total !== 16'd0) begin n_fail++; $display("FAIL mid_rx_total: %0d, required 0", rx_total); end
      rst_n = 1'b1;
      repeat (20) tick();
      n_checks += 2;
      if (n_load - base != 1) begin n_fail++; $display("FAIL mid_no_load: %0d, required 1", n_load - base); end
      if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL mid_post_count: %0d, required 0", fifo_count); end
      busy_len = 2;
      send(8'h77);
      wait_loads(base + 2, 40);
      n_checks++;
      if (n_load - base != 2 || txq[txq.size() - 1] !== 8'h77) begin
         n_fail++;
         $display("FAIL mid_resume: loads %0d last %h, required 2 and 77", n_load - base, txq[txq.size() - 1]);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_new  = 1'b0;
      mode    = MODE_ECHO;
      ovf_clr = 1'b0;
      test_reset();
      test_echo();
      test_upper();
      test_hold_overflow();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
